// File: rtl/rps_pkg.sv
// Shared move codes and encoder state for the rock/paper/scissors input path.
// The seven-segment move decoder uses the same move_t encoding.
package rps_pkg;

    typedef enum logic [2:0] {
        MOVE_NONE     = 3'b000,
        MOVE_ROCK     = 3'b100,
        MOVE_PAPER    = 3'b010,
        MOVE_SCISSORS = 3'b001
    } move_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMING   = 2'd1,
        HELD     = 2'd2,
        WAIT_REL = 2'd3
    } enc_state_t;

    function automatic logic is_one_hot(input logic [2:0] pat);
        return (pat == 3'b100) || (pat == 3'b010) || (pat == 3'b001);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for a bundle of raw asynchronous inputs.
// Both flop stages clear on reset, so no stale press survives a reset.
module btn_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage metastability filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/rps_move_encoder.sv
// Debounces the three player buttons and presents a single clean move with valid/ready.
// A full debounced release is required before the next move can be armed.
module rps_move_encoder
    import rps_pkg::*;
#(
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_rock,
    input  logic       btn_paper,
    input  logic       btn_scissors,
    input  logic       clear,
    input  logic       move_ready,
    output logic       move_valid,
    output logic [2:0] move_code
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [2:0]       pat_s;
    enc_state_t       state_q;
    move_t            cand_q;
    move_t            code_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    btn_sync #(
        .WIDTH (3)
    ) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i ({btn_rock, btn_paper, btn_scissors}),
        .sync_o  (pat_s)
    );

    // Encoder FSM with debounce counter and registered move outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cand_q  <= MOVE_NONE;
            code_q  <= MOVE_NONE;
            valid_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else if (clear) begin
            state_q <= WAIT_REL;
            code_q  <= MOVE_NONE;
            valid_q <= 1'b0;
            cnt_q   <= CNT_ZERO;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= CNT_ZERO;
                    if (is_one_hot(pat_s)) begin
                        state_q <= ARMING;
                        cand_q  <= move_t'(pat_s);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ARMING: begin
                    if (pat_s == cand_q) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= HELD;
                            code_q  <= cand_q;
                            valid_q <= 1'b1;
                        end else if (cnt_q < CNT_LAST) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end else if (is_one_hot(pat_s)) begin
                        cand_q <= move_t'(pat_s);
                        cnt_q  <= CNT_ZERO;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= CNT_ZERO;
                    end
                end
                HELD: begin
                    // Buttons are deliberately ignored until the consumer takes the move
                    if (valid_q && move_ready) begin
                        state_q <= WAIT_REL;
                        code_q  <= MOVE_NONE;
                        valid_q <= 1'b0;
                        cnt_q   <= CNT_ZERO;
                    end else begin
                        state_q <= HELD;
                    end
                end
                WAIT_REL: begin
                    if (pat_s == 3'b000) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            cnt_q   <= CNT_ZERO;
                        end else if (cnt_q < CNT_LAST) begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end else begin
                        cnt_q <= CNT_ZERO;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    code_q  <= MOVE_NONE;
                    valid_q <= 1'b0;
                    cnt_q   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign move_valid = valid_q;
    assign move_code  = code_q;

endmodule

// File: tb/tb_rps_move_encoder.sv
// Directed and randomized bench for rps_move_encoder with DEBOUNCE_CYCLES=4,
// checked cycle by cycle against a run-length model of the button rules.
module tb_rps_move_encoder;
    import rps_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_rock;
    logic       btn_paper;
    logic       btn_scissors;
    logic       clear;
    logic       move_ready;
    logic       move_valid;
    logic [2:0] move_code;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = seeking a press, 1 = holding a move, 2 = waiting for release
    int         m_phase;
    int         m_run;
    logic [2:0] m_run_pat;
    logic [2:0] m_s1;
    logic [2:0] m_s2;
    logic       m_valid;
    logic [2:0] m_code;

    rps_move_encoder #(
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_rock     (btn_rock),
        .btn_paper    (btn_paper),
        .btn_scissors (btn_scissors),
        .clear        (clear),
        .move_ready   (move_ready),
        .move_valid   (move_valid),
        .move_code    (move_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_run     = 0;
        m_run_pat = 3'b000;
        m_s1      = 3'b000;
        m_s2      = 3'b000;
        m_valid   = 1'b0;
        m_code    = 3'b000;
    endtask

    // A move is taken once N+1 identical one-hot samples are seen in a row;
    // a release needs N consecutive all-zero samples.
    task automatic model_step();
        logic [2:0] pat;
        pat = m_s2;
        if (reset) begin
            model_reset();
        end else begin
            if (clear) begin
                m_phase = 2;
                m_run   = 0;
                m_valid = 1'b0;
                m_code  = 3'b000;
            end else if (m_phase == 0) begin
                if ($countones(pat) == 1) begin
                    if (m_run > 0 && pat == m_run_pat) m_run++;
                    else begin
                        m_run_pat = pat;
                        m_run     = 1;
                    end
                    if (m_run == N + 1) begin
                        m_phase = 1;
                        m_valid = 1'b1;
                        m_code  = pat;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else if (m_phase == 1) begin
                if (move_ready) begin
                    m_phase = 2;
                    m_valid = 1'b0;
                    m_code  = 3'b000;
                    m_run   = 0;
                end
            end else begin
                if (pat == 3'b000) begin
                    m_run++;
                    if (m_run == N) begin
                        m_phase = 0;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = {btn_rock, btn_paper, btn_scissors};
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_valid", 32'(move_valid), 32'(m_valid));
        check("model_code", 32'(move_code), 32'(m_code));
    endtask

    task automatic set_btn(input logic [2:0] b);
        {btn_rock, btn_paper, btn_scissors} = b;
    endtask

    task automatic expect_latency(input string tag, input logic [2:0] code);
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check({tag, "_early"}, 32'(move_valid), 32'd0);
        end
        tick();
        check({tag, "_valid"}, 32'(move_valid), 32'd1);
        check({tag, "_code"}, 32'(move_code), 32'(code));
    endtask

    task automatic accept();
        move_ready = 1'b1;
        tick();
        move_ready = 1'b0;
        check("accept_valid", 32'(move_valid), 32'd0);
        check("accept_code", 32'(move_code), 32'd0);
    endtask

    initial begin
        logic [2:0] rnd_btn;
        reset = 1'b1;
        clear = 1'b0;
        move_ready = 1'b0;
        set_btn(3'b000);
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) tick();
        check("reset_valid", 32'(move_valid), 32'd0);
        check("reset_code", 32'(move_code), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Clean rock press, held, then a one-cycle ready pulse
        set_btn(3'b100);
        expect_latency("rock", 3'b100);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rock_hold", 32'(move_code), 32'(MOVE_ROCK));
        end
        accept();
        set_btn(3'b000);
        for (int i = 0; i < 8; i++) tick();

        // Bouncing paper
        for (int i = 0; i < 4; i++) begin
            set_btn((i % 2 == 0) ? 3'b010 : 3'b000);
            tick();
            check("bounce_novalid", 32'(move_valid), 32'd0);
        end
        set_btn(3'b010);
        expect_latency("paper", 3'b010);
        accept();
        set_btn(3'b000);
        for (int i = 0; i < 8; i++) tick();

        // Rock+scissors chord, then release rock
        set_btn(3'b101);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("chord_novalid", 32'(move_valid), 32'd0);
        end
        set_btn(3'b001);
        expect_latency("scissors", 3'b001);
        accept();

        // Re-arm lockout
        for (int i = 0; i < 30; i++) begin
            tick();
            check("lockout_held", 32'(move_valid), 32'd0);
        end
        set_btn(3'b000);
        for (int i = 0; i < 3; i++) tick();
        set_btn(3'b001);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("lockout_short_rel", 32'(move_valid), 32'd0);
        end
        set_btn(3'b000);
        for (int i = 0; i < N + 2; i++) tick();
        set_btn(3'b001);
        expect_latency("rearm", 3'b001);

        // clear beats a simultaneous accept
        clear = 1'b1;
        move_ready = 1'b1;
        tick();
        clear = 1'b0;
        move_ready = 1'b0;
        check("clear_valid", 32'(move_valid), 32'd0);
        check("clear_state", 32'(dut.state_q), 32'(WAIT_REL));
        set_btn(3'b000);
        for (int i = 0; i < 8; i++) tick();

        // Async reset mid-ARMING, between edges
        set_btn(3'b100);
        for (int i = 0; i < 4; i++) tick();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset_arm_valid", 32'(move_valid), 32'd0);
        check("areset_arm_code", 32'(move_code), 32'd0);
        tick();
        reset = 1'b0;
        expect_latency("post_reset", 3'b100);

        // Async reset while HELD
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("areset_held_valid", 32'(move_valid), 32'd0);
        check("areset_held_code", 32'(move_code), 32'd0);
        tick();
        reset = 1'b0;
        expect_latency("post_reset2", 3'b100);
        accept();
        set_btn(3'b000);
        for (int i = 0; i < 8; i++) tick();

        // Randomized buttons, ready and occasional clear
        rnd_btn = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) begin
                if ($urandom_range(2) == 0) rnd_btn = 3'($urandom_range(7));
                else rnd_btn = 3'b001 << $urandom_range(2);
            end
            set_btn(rnd_btn);
            move_ready = ($urandom_range(3) == 0);
            clear = ($urandom_range(60) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
